// File: rtl/i2c_master_core.sv
// Byte-level I2C master: one START/address/register/data(/repeated START/read)/STOP transaction per command.
// Define I2C_MASTER_STRETCH_EN to let a slave stretch SCL; by default SCL is never sampled.
module i2c_master_core #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        SDA,
    inout  wire        SCL,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       nack
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_TX_BYTE, S_RX_ACK, S_RSTART, S_RX_BYTE, S_TX_NACK, S_STOP
    } state_t;

    typedef enum logic [2:0] {
        PH_ADDR_W, PH_REG, PH_DATA_W, PH_ADDR_R, PH_DATA_R
    } phase_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [1:0]  quarter_q, quarter_d;
    logic [2:0]  bitCnt_q, bitCnt_d;
    logic [15:0] divCnt_q, divCnt_d;
    logic [7:0]  txShift_q, txShift_d;
    logic [7:0]  rxShift_q, rxShift_d;
    logic        ackBit_q, ackBit_d;
    logic        rw_q, rw_d;
    logic [6:0]  devAddr_q, devAddr_d;
    logic [7:0]  regAddr_q, regAddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        nack_q, nack_d;
    logic        sclLow_q, sclLow_d;
    logic        sdaLow_q, sdaLow_d;

    logic sdaIn;
    logic stall;
    logic tick;

    assign sdaIn = SDA;

    // A slave holding SCL low freezes the quarter counter at the start of any quarter where we release SCL.
`ifdef I2C_MASTER_STRETCH_EN
    assign stall = (state_q != S_IDLE) && !sclLow_q && (divCnt_q == 16'd0) && (SCL == 1'b0);
`else
    assign stall = 1'b0;
`endif

    assign tick = (divCnt_q == DIV_LAST) && !stall;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        quarter_d = quarter_q;
        bitCnt_d  = bitCnt_q;
        divCnt_d  = 16'd0;
        txShift_d = txShift_q;
        rxShift_d = rxShift_q;
        ackBit_d  = ackBit_q;
        rw_d      = rw_q;
        devAddr_d = devAddr_q;
        regAddr_d = regAddr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        nack_d    = nack_q;
        sclLow_d  = 1'b0;
        sdaLow_d  = 1'b0;

        if (state_q != S_IDLE && !tick) begin
            divCnt_d = stall ? divCnt_q : divCnt_q + 16'd1;
        end

        if (state_q == S_IDLE) begin
            quarter_d = 2'd0;
            if (start) begin
                state_d   = S_START;
                bitCnt_d  = 3'd0;
                busy_d    = 1'b1;
                nack_d    = 1'b0;
                rw_d      = rw;
                devAddr_d = dev_addr;
                regAddr_d = reg_addr;
                wdata_d   = wdata;
            end
        end else if (tick) begin
            quarter_d = quarter_q + 2'd1;
            // Receive sampling happens at the q2->q3 boundary, with SCL already high for a quarter.
            if (quarter_q == 2'd2) begin
                if (state_q == S_RX_ACK) ackBit_d = sdaIn;
                if (state_q == S_RX_BYTE) rxShift_d = {rxShift_q[6:0], sdaIn};
            end
            if (quarter_q == 2'd3) begin
                case (state_q)
                    S_START: begin
                        state_d   = S_TX_BYTE;
                        phase_d   = PH_ADDR_W;
                        txShift_d = {devAddr_q, 1'b0};
                        bitCnt_d  = 3'd0;
                    end
                    S_TX_BYTE: begin
                        if (bitCnt_q == 3'd7) begin
                            state_d = S_RX_ACK;
                        end else begin
                            bitCnt_d  = bitCnt_q + 3'd1;
                            txShift_d = {txShift_q[6:0], 1'b0};
                        end
                    end
                    S_RX_ACK: begin
                        if (ackBit_q) begin
                            nack_d  = 1'b1;
                            state_d = S_STOP;
                        end else begin
                            case (phase_q)
                                PH_ADDR_W: begin
                                    state_d   = S_TX_BYTE;
                                    phase_d   = PH_REG;
                                    txShift_d = regAddr_q;
                                    bitCnt_d  = 3'd0;
                                end
                                PH_REG: begin
                                    if (rw_q) begin
                                        state_d = S_RSTART;
                                    end else begin
                                        state_d   = S_TX_BYTE;
                                        phase_d   = PH_DATA_W;
                                        txShift_d = wdata_q;
                                        bitCnt_d  = 3'd0;
                                    end
                                end
                                PH_ADDR_R: begin
                                    state_d  = S_RX_BYTE;
                                    phase_d  = PH_DATA_R;
                                    bitCnt_d = 3'd0;
                                end
                                default: state_d = S_STOP;
                            endcase
                        end
                    end
                    S_RSTART: begin
                        state_d   = S_TX_BYTE;
                        phase_d   = PH_ADDR_R;
                        txShift_d = {devAddr_q, 1'b1};
                        bitCnt_d  = 3'd0;
                    end
                    S_RX_BYTE: begin
                        if (bitCnt_q == 3'd7) begin
                            state_d = S_TX_NACK;
                        end else begin
                            bitCnt_d = bitCnt_q + 3'd1;
                        end
                    end
                    S_TX_NACK: state_d = S_STOP;
                    S_STOP: begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        if (rw_q && !nack_q) rdata_d = rxShift_q;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        // Line levels are decoded from the upcoming state/quarter so the pins are registered.
        case (state_d)
            S_START: sdaLow_d = quarter_d[1];
            S_TX_BYTE: begin
                sclLow_d = !quarter_d[1];
                sdaLow_d = !txShift_d[7];
            end
            S_RX_ACK, S_RX_BYTE, S_TX_NACK: sclLow_d = !quarter_d[1];
            S_RSTART: begin
                sclLow_d = (quarter_d == 2'd0);
                sdaLow_d = quarter_d[1];
            end
            S_STOP: begin
                sclLow_d = (quarter_d == 2'd0);
                sdaLow_d = !quarter_d[1];
            end
            default: begin
                sclLow_d = 1'b0;
                sdaLow_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            phase_q   <= PH_ADDR_W;
            quarter_q <= 2'd0;
            bitCnt_q  <= 3'd0;
            divCnt_q  <= 16'd0;
            txShift_q <= 8'h00;
            rxShift_q <= 8'h00;
            ackBit_q  <= 1'b0;
            rw_q      <= 1'b0;
            devAddr_q <= 7'h00;
            regAddr_q <= 8'h00;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            nack_q    <= 1'b0;
            sclLow_q  <= 1'b0;
            sdaLow_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            quarter_q <= quarter_d;
            bitCnt_q  <= bitCnt_d;
            divCnt_q  <= divCnt_d;
            txShift_q <= txShift_d;
            rxShift_q <= rxShift_d;
            ackBit_q  <= ackBit_d;
            rw_q      <= rw_d;
            devAddr_q <= devAddr_d;
            regAddr_q <= regAddr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            nack_q    <= nack_d;
            sclLow_q  <= sclLow_d;
            sdaLow_q  <= sdaLow_d;
        end
    end

    assign SDA   = sdaLow_q ? 1'b0 : 1'bz;
    assign SCL   = sclLow_q ? 1'b0 : 1'bz;
    assign rdata = rdata_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign nack  = nack_q;

endmodule

// File: tb/tb_i2c_master_core.sv
// Bench for i2c_master_core: a behavioural I2C slave on the pulled-up bus plus a transaction-level
// reference model (expected bus bytes, duration, nack and rdata per command).
module tb_i2c_master_core;

    localparam int         CLK_DIV    = 4;
    localparam logic [6:0] SLAVE_ADDR = 7'h50;
    localparam int         LIMIT      = 200 * CLK_DIV + 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       rw;
    logic [6:0] devAddr;
    logic [7:0] regAddr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       nack;
    wire        sdaBus;
    wire        sclBus;
    logic       slaveSdaLow = 1'b0;

    pullup (sdaBus);
    pullup (sclBus);
    assign sdaBus = slaveSdaLow ? 1'b0 : 1'bz;

    i2c_master_core #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .SDA      (sdaBus),
        .SCL      (sclBus),
        .start    (start),
        .rw       (rw),
        .dev_addr (devAddr),
        .reg_addr (regAddr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .nack     (nack)
    );

    always #5 clk = ~clk;

    int         checks;
    int         errors;
    logic [7:0] refMem [256];
    logic [7:0] expRdata;

    // Slave model state, owned by the slave process only.
    logic [7:0] slaveMem [256];
    logic [7:0] busLog [$];
    logic       memReady = 1'b0;
    logic       sclPrev = 1'b1;
    logic       sdaPrev = 1'b1;
    logic       sclNow;
    logic       sdaNow;
    logic       readMode = 1'b0;
    logic       readPending = 1'b0;
    logic       addressed = 1'b0;
    logic [7:0] shiftIn = 8'h00;
    logic [7:0] sendByte = 8'h00;
    logic [7:0] regPtr = 8'h00;
    int         bitPos = 0;
    int         byteNum = 0;
    int         startCount = 0;
    int         stopCount = 0;
    int         masterNackCount = 0;

    // Cycle-sampled slave: detects START/STOP and SCL edges from the previous sample.
    always @(negedge clk) begin
        if (!memReady) begin
            for (int i = 0; i < 256; i++) slaveMem[i] = 8'(i) ^ 8'h3F;
            memReady = 1'b1;
        end
        sclNow = sclBus;
        sdaNow = sdaBus;
        if (reset) begin
            slaveSdaLow = 1'b0;
            bitPos      = 0;
            byteNum     = 0;
            readMode    = 1'b0;
            readPending = 1'b0;
            addressed   = 1'b0;
        end else if (sclPrev && sclNow && sdaPrev && !sdaNow) begin
            startCount++;
            bitPos      = 0;
            byteNum     = 0;
            readMode    = 1'b0;
            readPending = 1'b0;
            shiftIn     = 8'h00;
            slaveSdaLow = 1'b0;
        end else if (sclPrev && sclNow && !sdaPrev && sdaNow) begin
            stopCount++;
            readMode    = 1'b0;
            slaveSdaLow = 1'b0;
        end else if (!sclPrev && sclNow) begin
            if (bitPos < 8 && !readMode) shiftIn = {shiftIn[6:0], sdaNow};
            if (bitPos == 8 && readMode && sdaNow) masterNackCount++;
            bitPos++;
        end else if (sclPrev && !sclNow) begin
            if (bitPos == 8 && !readMode) begin
                busLog.push_back(shiftIn);
                if (byteNum == 0) begin
                    addressed   = (shiftIn[7:1] == SLAVE_ADDR);
                    readPending = addressed && shiftIn[0];
                end else if (addressed && byteNum == 1) begin
                    regPtr = shiftIn;
                end else if (addressed && byteNum == 2) begin
                    slaveMem[regPtr] = shiftIn;
                end
                slaveSdaLow = addressed;
                byteNum++;
            end else if (bitPos == 8) begin
                slaveSdaLow = 1'b0;
            end else if (bitPos >= 9) begin
                bitPos      = 0;
                slaveSdaLow = 1'b0;
                if (readPending) begin
                    readMode    = 1'b1;
                    readPending = 1'b0;
                    sendByte    = slaveMem[regPtr];
                    slaveSdaLow = !sendByte[7];
                end
            end else if (readMode) begin
                slaveSdaLow = !sendByte[3'(7 - bitPos)];
            end
        end
        sclPrev = sclNow;
        sdaPrev = sdaNow;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rwIn, input logic [6:0] dev, input logic [7:0] regA,
                                 input logic [7:0] wd, input logic poke);
        logic       acked;
        int         expLen;
        logic [7:0] expBytes [$];
        int         logBase;
        int         startBase;
        int         stopBase;
        int         nackBase;
        int         cycles;
        int         waitCnt;
        logic       sawDone;

        acked = (dev == SLAVE_ADDR);
        expBytes.push_back({dev, 1'b0});
        if (acked) begin
            expBytes.push_back(regA);
            expBytes.push_back(rwIn ? {dev, 1'b1} : wd);
        end
        expLen = !acked ? 44 * CLK_DIV : (rwIn ? 156 * CLK_DIV : 116 * CLK_DIV);
        if (acked && !rwIn) refMem[regA] = wd;
        if (acked && rwIn) expRdata = refMem[regA];

        logBase   = busLog.size();
        startBase = startCount;
        stopBase  = stopCount;
        nackBase  = masterNackCount;

        @(posedge clk);
        #1;
        start   = 1'b1;
        rw      = rwIn;
        devAddr = dev;
        regAddr = regA;
        wdata   = wd;
        @(posedge clk);
        #1;
        start = 1'b0;

        cycles  = 0;
        waitCnt = 0;
        sawDone = 1'b0;
        while (!sawDone && waitCnt < LIMIT) begin
            @(negedge clk);
            waitCnt++;
            if (poke && cycles == 40) begin
                start = 1'b1;
                wdata = ~wd;
            end else begin
                start = 1'b0;
            end
            if (done) sawDone = 1'b1;
            else if (busy) cycles++;
        end
        start = 1'b0;

        if (!sawDone) begin
            checkOutput("done_timeout", 32'd0, 32'd1);
        end else begin
            checkOutput("length", cycles, expLen);
            checkOutput("nack", nack, !acked);
            checkOutput("busy_at_done", busy, 0);
            checkOutput("rdata", rdata, expRdata);
            checkOutput("byte_count", busLog.size() - logBase, expBytes.size());
            for (int i = 0; i < expBytes.size() && logBase + i < busLog.size(); i++)
                checkOutput($sformatf("bus_byte%0d", i), busLog[logBase + i], expBytes[i]);
            checkOutput("starts", startCount - startBase, (acked && rwIn) ? 2 : 1);
            checkOutput("stops", stopCount - stopBase, 1);
            checkOutput("master_nack", masterNackCount - nackBase, (acked && rwIn) ? 1 : 0);
            @(negedge clk);
            checkOutput("done_pulse", done, 0);
        end
    endtask

    // Abort a read in the middle of data bit 4; nothing may finish and both lines must float.
    task automatic midReadReset();
        int   cycles;
        int   waitCnt;
        logic doneSeen;

        @(posedge clk);
        #1;
        start   = 1'b1;
        rw      = 1'b1;
        devAddr = SLAVE_ADDR;
        regAddr = 8'h10;
        @(posedge clk);
        #1;
        start = 1'b0;

        cycles  = 0;
        waitCnt = 0;
        while (cycles < 134 * CLK_DIV && waitCnt < LIMIT) begin
            @(negedge clk);
            waitCnt++;
            if (busy) cycles++;
        end
        checkOutput("midread_busy", busy, 1);
        checkOutput("midread_done", done, 0);

        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_scl", sclBus, 1);
        checkOutput("abort_sda", sdaBus, 1);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        expRdata = 8'h00;

        doneSeen = 1'b0;
        for (int i = 0; i < 8 * CLK_DIV; i++) begin
            @(negedge clk);
            if (done || busy) doneSeen = 1'b1;
        end
        checkOutput("abort_quiet", doneSeen, 0);
        checkOutput("abort_rdata", rdata, expRdata);
        checkOutput("abort_nack", nack, 0);
    endtask

    initial begin
        logic       rRw;
        logic [6:0] rDev;
        logic [7:0] rReg;
        logic [7:0] rData;

        checks   = 0;
        errors   = 0;
        expRdata = 8'h00;
        for (int i = 0; i < 256; i++) refMem[i] = 8'(i) ^ 8'h3F;

        reset   = 1'b1;
        start   = 1'b0;
        rw      = 1'b0;
        devAddr = 7'h00;
        regAddr = 8'h00;
        wdata   = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_scl", sclBus, 1);
        checkOutput("reset_sda", sdaBus, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_nack", nack, 0);
        checkOutput("reset_rdata", rdata, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] directed transactions");
        applyStimulus(1'b1, SLAVE_ADDR, 8'h03, 8'h00, 1'b0);
        applyStimulus(1'b0, SLAVE_ADDR, 8'h03, 8'hA5, 1'b0);
        applyStimulus(1'b1, SLAVE_ADDR, 8'h03, 8'h00, 1'b0);
        applyStimulus(1'b0, 7'h21, 8'h07, 8'h11, 1'b0);
        applyStimulus(1'b0, SLAVE_ADDR, 8'h20, 8'h5A, 1'b1);
        applyStimulus(1'b1, SLAVE_ADDR, 8'h20, 8'h00, 1'b0);
        midReadReset();
        applyStimulus(1'b0, SLAVE_ADDR, 8'h40, 8'hC3, 1'b0);
        applyStimulus(1'b1, SLAVE_ADDR, 8'h40, 8'h00, 1'b0);

        $display("[TB] random transactions");
        for (int n = 0; n < 14; n++) begin
            rRw   = 1'($urandom_range(0, 1));
            rReg  = 8'($urandom_range(0, 255));
            rData = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                rDev = SLAVE_ADDR;
            end else begin
                rDev = 7'($urandom_range(0, 127));
                if (rDev == SLAVE_ADDR) rDev = rDev ^ 7'h01;
            end
            applyStimulus(rRw, rDev, rReg, rData, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_master_core.md
# i2c_master_core

Byte-level I2C master that issues complete single-register transactions (write: START, device address+W, register byte, data byte, STOP; read: START, device address+W, register byte, repeated START, device address+R, data byte with master NACK, STOP). Initiator counterpart of the I2C slave: drives `SCL` and `SDA` open-drain on the same bus and shares the system `clk`. A host loads one command per transaction and receives a done pulse, a NACK flag and read data.

## Interface
- `CLK_DIV`, default 250: `clk` cycles per SCL quarter-period Q; legal range 2..65535. SCL period = 4·Q.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `SDA`  inout  1  open-drain: driven 0 or `1'bz`, never 1.
- `SCL`  inout  1  open-drain: driven 0 or `1'bz`, never 1; sampled only with stretching.
- `start`  input  1  single-cycle command strobe; accepted only when `busy`=0.
- `rw`  input  1  0 = register write, 1 = register read; captured with `start`.
- `dev_addr`  input  7  slave address; captured with `start`.
- `reg_addr`  input  8  register/memory address; captured with `start`.
- `wdata`  input  8  write byte; captured with `start`.
- `rdata`  output  8  byte read; updated only on successful read completion.
- `busy`  output  1  high from the cycle after accepted `start` until `done`.
- `done`  output  1  one-cycle pulse at transaction end (success or NACK).
- `nack`  output  1  valid with `done`; 1 if any slave ACK slot sampled high. Held until next accepted `start`.

## Operation
- Quarter tick: counter 0..CLK_DIV-1, wraps; tick when counter = CLK_DIV-1. Counter held at 0 in IDLE.
- States: IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_NACK, STOP. Byte/phase sequencer tracks ADDR_W, REG, DATA_W, ADDR_R, DATA_R.
- START: SDA released, SCL released for 2Q; SDA low 2Q; then SCL low.
- Bit slot, 4 quarters: q0 SCL low, SDA updated; q1 SCL low; q2, q3 SCL released. Receiver samples SDA at the q2→q3 boundary. MSB first.
- TX_BYTE: 8 slots from a shift register (`{dev_addr,rw_bit}`, `reg_addr`, or `wdata`), then RX_ACK with SDA released.
- RX_ACK sampled 1: set `nack`, skip remaining bytes, go to STOP.
- RSTART (read only, after REG ACK): SDA released with SCL low Q, SCL released Q, SDA low 2Q, SCL low.
- RX_BYTE: SDA released 8 slots, sampled bits shift into a temporary register. TX_NACK: SDA released for the 9th slot. Copy temporary to `rdata` at STOP completion only.
- STOP: SDA low, SCL low Q; SCL released Q; SDA released, hold 2Q; then `done`=1 for one cycle, `busy`=0, return to IDLE.
- `start` while `busy`=1 is ignored, with no capture.
- `reset` at any cycle: both lines released the next cycle, FSM to IDLE, counters 0. No STOP is generated. Bus recovery is the host's job.
- Reset values: `SCL`=z, `SDA`=z, `busy`=0, `done`=0, `nack`=0, `rdata`=8'h00.

## Timing
- `start` accepted at edge N: `busy`=1 at N+1, first quarter begins at N+1.
- Write, all ACKed: 4Q (START) + 27·4Q + 4Q (STOP) = 116·Q cycles. `done` asserts in the following cycle.
- Read, all ACKed: 4Q + 18·4Q + 4Q (RSTART) + 18·4Q + 4Q = 156·Q cycles, then `done`.
- NACK at address: 4Q + 9·4Q + 4Q = 44·Q, then `done` with `nack`=1.
- `done` and `busy` fall together. A new `start` is legal in the cycle `done` is high.

## Configuration
- `I2C_MASTER_STRETCH_EN` defined: at each q2 and at STOP/START/RSTART release points, the quarter counter holds at 0 while `SCL` samples 0. Stretching is unbounded. Timing figures are extended by the stall cycles.
- Undefined: `SCL` is never sampled. Timing is exactly as stated.

## Test plan
- Write: `dev_addr`=0x50, `reg_addr`=0x03, `wdata`=0xA5, slave ACKs, CLK_DIV=4 -> bus bytes 0xA0, 0x03, 0xA5; `done` 464 cycles after `busy` rises; `nack`=0; slave mem[0x03]=0xA5.
- Read: dev 0x50, reg 0x03, slave returns 0x3C -> bus 0xA0, 0x03, RSTART, 0xA1; master SDA released on 9th bit of data; `rdata`=0x3C; `nack`=0; 624 cycles.
- Absent slave 0x21 -> byte 0x42, ACK slot high -> STOP follows immediately; `done` with `nack`=1; `rdata` unchanged.
- `start` pulsed again mid-transaction with different `wdata` -> ignored; bus bytes match the first command.
- `reset` asserted during RX_BYTE bit 4 -> next cycle `SCL`=z, `SDA`=z, `busy`=0, no `done`. A subsequent write completes normally.
- With `I2C_MASTER_STRETCH_EN`: slave holds SCL low 37 cycles after address ACK -> transaction length = nominal + 37 cycles, data intact.
